// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin front end for a registered logic unit (AND/OR/NAND/NOR).
// One operation in flight at a time: IDLE grant -> ISSUE pulse -> WAIT capture -> RESP handshake.
module logic_op_arbiter #(
  parameter int WIDTH_IN_DATA  = 16,
  parameter int WIDTH_OUT_DATA = 16
) (
  input  logic                      CLK_logic,
  input  logic                      RST_logic,
  input  logic [1:0]                req_valid,
  input  logic [WIDTH_IN_DATA-1:0]  req_a0,
  input  logic [WIDTH_IN_DATA-1:0]  req_b0,
  input  logic [WIDTH_IN_DATA-1:0]  req_a1,
  input  logic [WIDTH_IN_DATA-1:0]  req_b1,
  input  logic [1:0]                req_fun0,
  input  logic [1:0]                req_fun1,
  output logic [1:0]                req_ready,
  output logic [WIDTH_IN_DATA-1:0]  A_logic,
  output logic [WIDTH_IN_DATA-1:0]  B_logic,
  output logic [1:0]                ALU_FUN_logic,
  output logic                      Logic_Enable,
  input  logic [WIDTH_OUT_DATA:0]   Logic_OUT,
  input  logic                      Logic_Flag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [WIDTH_OUT_DATA:0]   rsp_data,
  output logic                      rsp_err,
  output logic [7:0]                op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   state, state_nxt;
  logic                     last_gnt;
  logic                     gnt_id;
  logic                     accept;
  logic [1:0][WIDTH_IN_DATA-1:0] req_a, req_b;
  logic [1:0][1:0]          req_fun;
  logic [WIDTH_IN_DATA-1:0] a_q, b_q;
  logic [1:0]               fun_q;
  logic                     id_q;

  assign req_a   = {req_a1, req_a0};
  assign req_b   = {req_b1, req_b0};
  assign req_fun = {req_fun1, req_fun0};

  // On contention the requester not granted last wins; a lone requester always wins.
  always_comb begin
    if (&req_valid) gnt_id = ~last_gnt;
    else            gnt_id = req_valid[1];
  end

  assign accept = (state == IDLE) && (|req_valid);

  always_ff @(posedge CLK_logic or negedge RST_logic) begin
    if (!RST_logic) state <= IDLE;
    else            state <= state_nxt;
  end

  // req_ready is gated by the reset pin so it drops the moment reset asserts.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    Logic_Enable  = 1'b0;
    A_logic       = '0;
    B_logic       = '0;
    ALU_FUN_logic = '0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (RST_logic) req_ready[gnt_id] = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        Logic_Enable  = 1'b1;
        A_logic       = a_q;
        B_logic       = b_q;
        ALU_FUN_logic = fun_q;
        state_nxt     = WAIT;
      end
      WAIT: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_logic or negedge RST_logic) begin
    if (!RST_logic) begin
      last_gnt <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      id_q     <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        last_gnt <= gnt_id;
        a_q      <= req_a[gnt_id];
        b_q      <= req_b[gnt_id];
        fun_q    <= req_fun[gnt_id];
        id_q     <= gnt_id;
      end
      // Logic unit output is registered, so it is valid during WAIT.
      if (state == WAIT) begin
        rsp_data <= Logic_OUT;
        rsp_id   <= id_q;
        rsp_err  <= ~Logic_Flag;
      end
      if (state == RESP && rsp_ready) op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: directed vector table, hand sequences for backpressure,
// error and mid-op reset, then random transactions checked against a transaction-level model.
module tb_logic_op_arbiter;

  logic        CLK_logic = 1'b0;
  logic        RST_logic;
  logic [1:0]  req_valid;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_fun0, req_fun1;
  logic [1:0]  req_ready;
  logic [15:0] A_logic, B_logic;
  logic [1:0]  ALU_FUN_logic;
  logic        Logic_Enable;
  logic [16:0] Logic_OUT = '0;
  logic        Logic_Flag = 1'b0;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [16:0] rsp_data;
  logic [7:0]  op_count;
  bit          err_inject = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_last  = 1'b1;
  int m_count = 0;

  always #5 CLK_logic = ~CLK_logic;

  logic_op_arbiter #(.WIDTH_IN_DATA(16), .WIDTH_OUT_DATA(16)) dut (
    .CLK_logic(CLK_logic), .RST_logic(RST_logic), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_fun0(req_fun0), .req_fun1(req_fun1), .req_ready(req_ready),
    .A_logic(A_logic), .B_logic(B_logic), .ALU_FUN_logic(ALU_FUN_logic),
    .Logic_Enable(Logic_Enable), .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
  );

  function automatic logic [16:0] lu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
    case (f)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a | b};
      2'd2:    return ~{1'b0, a & b};
      default: return ~{1'b0, a | b};
    endcase
  endfunction

  // Registered logic unit stand-in: result and flag appear one edge after Logic_Enable.
  always @(posedge CLK_logic) begin
    if (Logic_Enable) begin
      Logic_OUT  <= lu(A_logic, B_logic, ALU_FUN_logic);
      Logic_Flag <= !err_inject;
    end else begin
      Logic_Flag <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic scramble();
    req_a0 = 16'($urandom); req_b0 = 16'($urandom);
    req_a1 = 16'($urandom); req_b1 = 16'($urandom);
    req_fun0 = 2'($urandom); req_fun1 = 2'($urandom);
  endtask

  // Called at a negedge with DUT in IDLE; returns at the negedge after the response handshake.
  task automatic run_op(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1,
                        input logic [1:0] f0, input logic [1:0] f1, input int hold, input bit err,
                        input bit have_exp, input bit exp_id, input logic [16:0] exp_data);
    bit          e_id;
    logic [15:0] ea, eb;
    logic [1:0]  ef;
    logic [16:0] ed;
    req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    req_fun0 = f0; req_fun1 = f1;
    rsp_ready = (hold == 0); err_inject = err;
    if (have_exp)      e_id = exp_id;
    else if (v == 2'b11) e_id = ~m_last;
    else               e_id = v[1];
    ea = e_id ? a1 : a0; eb = e_id ? b1 : b0; ef = e_id ? f1 : f0;
    ed = have_exp ? exp_data : lu(ea, eb, ef);
    #1 chk("req_ready_grant", req_ready, 2'b01 << e_id);
    m_last = e_id;
    @(negedge CLK_logic);
    scramble();
    req_valid = 2'($urandom);
    #1;
    chk("issue_enable", Logic_Enable, 1);
    chk("issue_A", A_logic, ea);
    chk("issue_B", B_logic, eb);
    chk("issue_fun", ALU_FUN_logic, ef);
    chk("issue_ready", req_ready, 0);
    @(negedge CLK_logic);
    chk("wait_enable", Logic_Enable, 0);
    chk("wait_A", A_logic, 0);
    chk("wait_rsp_valid", rsp_valid, 0);
    @(negedge CLK_logic);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, ed);
    chk("resp_id", rsp_id, e_id);
    chk("resp_err", rsp_err, err);
    req_valid = 2'b11;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK_logic);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_id", rsp_id, e_id);
      chk("hold_ready", req_ready, 0);
      chk("hold_enable", Logic_Enable, 0);
    end
    rsp_ready = 1'b1;
    @(negedge CLK_logic);
    req_valid = 2'b00;
    m_count = (m_count + 1) % 256;
    #1;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("op_count", op_count, m_count);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  f0, f1;
    bit          id;
    logic [16:0] data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{2'b01, 16'h00FF, 16'h0F0F, 16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0, 17'h0000F};
    tbl[1] = '{2'b10, 16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF, 2'd1, 2'd2, 1'b1, 17'h10000};
    tbl[2] = '{2'b11, 16'h1234, 16'h00FF, 16'hF0F0, 16'h0FF0, 2'd1, 2'd3, 1'b0, 17'h012FF};
    tbl[3] = '{2'b11, 16'h1234, 16'h00FF, 16'hF0F0, 16'h0FF0, 2'd1, 2'd3, 1'b1, 17'h1000F};
    tbl[4] = '{2'b11, 16'h1234, 16'h00FF, 16'hF0F0, 16'h0FF0, 2'd1, 2'd3, 1'b0, 17'h012FF};
    tbl[5] = '{2'b11, 16'h1234, 16'h00FF, 16'hF0F0, 16'h0FF0, 2'd1, 2'd3, 1'b1, 17'h1000F};

    RST_logic = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    scramble();
    #22;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_enable", Logic_Enable, 0);
    chk("rst_A", A_logic, 0);
    chk("rst_fun", ALU_FUN_logic, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_op_count", op_count, 0);
    req_valid = 2'b00; rsp_ready = 1'b0;
    @(negedge CLK_logic);
    RST_logic = 1'b1;
    @(negedge CLK_logic);
    chk("idle_rsp_valid", rsp_valid, 0);

    foreach (tbl[i])
      run_op(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].f0, tbl[i].f1,
             0, 1'b0, 1'b1, tbl[i].id, tbl[i].data);

    // Backpressure, then the error path.
    run_op(2'b01, 16'hA5A5, 16'h5A5A, 16'h0, 16'h0, 2'd1, 2'd0, 5, 1'b0, 1'b1, 1'b0, 17'h0FFFF);
    run_op(2'b10, 16'h0, 16'h0, 16'hFF00, 16'h0F0F, 2'd0, 2'd0, 0, 1'b1, 1'b1, 1'b1, 17'h00F00);

    // Reset while WAIT: no response afterwards, arbitration restarts at requester 0.
    req_valid = 2'b01; req_a0 = 16'hFFFF; req_b0 = 16'h1234; req_fun0 = 2'd0; rsp_ready = 1'b1;
    @(negedge CLK_logic);
    req_valid = 2'b11;
    @(negedge CLK_logic);
    RST_logic = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_enable", Logic_Enable, 0);
    req_valid = 2'b00;
    m_count = 0; m_last = 1'b1;
    @(negedge CLK_logic);
    RST_logic = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_logic);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    run_op(2'b11, 16'h0F0F, 16'h00FF, 16'h1, 16'h1, 2'd3, 2'd0, 0, 1'b0, 1'b1, 1'b0, 17'h1F000);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             2'($urandom), 2'($urandom), int'($urandom_range(0, 2)), ($urandom % 5) == 0,
             1'b0, 1'b0, 17'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
